// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: Y86 pipeline stall/bubble control with multi-cycle load-use, ret penalty, sticky halt and hazard counters
module pipe_hazard_ctrl #(
    parameter int REG_W     = 4,
    parameter int MEM_LAT   = 1,
    parameter int RET_STALL = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [3:0]       D_icode_i,
    input  logic [REG_W-1:0] d_srcA_i,
    input  logic [REG_W-1:0] d_srcB_i,
    input  logic [3:0]       E_icode_i,
    input  logic [REG_W-1:0] E_dstM_i,
    input  logic             e_Cnd_i,
    input  logic [3:0]       M_icode_i,
    input  logic [2:0]       m_stat_i,
    input  logic [2:0]       W_stat_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             D_bubble_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             W_stall_o,
    output logic             set_cc_o,
    output logic             halted_o,
    output logic [2:0]       exc_stat_o,
    output logic [CNT_W-1:0] lu_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o,
    output logic [CNT_W-1:0] ret_cnt_o
);
    localparam logic [3:0] IMRMOVQ = 4'h5, IOPQ = 4'h6, IJXX = 4'h7, IRET = 4'h9, IPOPQ = 4'hB;
    localparam logic [2:0] SAOK = 3'd1, SADR = 3'd2, SINS = 3'd3, SHLT = 3'd4;
    localparam logic [REG_W-1:0] RNONE = '1;
    localparam int WMAX = MEM_LAT > RET_STALL ? MEM_LAT : RET_STALL;
    localparam int WC_W = $clog2(WMAX + 1);

    typedef enum logic [1:0] {RUN, LU_WAIT, RET_WAIT, HALT} state_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wcnt, wcnt_nxt;
    logic            mis, lu, is_ret, m_exc, w_exc;
    logic            lu_inc, mis_inc, ret_inc;
    logic            unused_m;

    function automatic logic exc(input logic [2:0] s);
        return s == SADR || s == SINS || s == SHLT;
    endfunction

    // M_icode is part of the stage interface but no hazard here depends on it
    assign unused_m = ^M_icode_i;
    assign m_exc    = exc(m_stat_i);
    assign w_exc    = exc(W_stat_i);
    assign mis      = E_icode_i == IJXX && !e_Cnd_i;
    assign is_ret   = D_icode_i == IRET;
    assign lu       = (E_icode_i == IMRMOVQ || E_icode_i == IPOPQ) && E_dstM_i != RNONE &&
                      (E_dstM_i == d_srcA_i || E_dstM_i == d_srcB_i);
    assign halted_o = state == HALT;

    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        lu_inc     = 1'b0;
        mis_inc    = 1'b0;
        ret_inc    = 1'b0;
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_bubble_o = m_exc || w_exc;
        W_stall_o  = w_exc;
        set_cc_o   = E_icode_i == IOPQ && !m_exc && !w_exc && state != HALT;
        case (state)
            RUN: begin
                if (w_exc) begin
                    state_nxt = HALT;
                end else if (mis) begin
                    D_bubble_o = 1'b1;
                    E_bubble_o = 1'b1;
                    mis_inc    = 1'b1;
                end else if (lu) begin
                    F_stall_o  = 1'b1;
                    D_stall_o  = 1'b1;
                    E_bubble_o = 1'b1;
                    lu_inc     = 1'b1;
                    if (MEM_LAT > 1) begin
                        state_nxt = LU_WAIT;
                        wcnt_nxt  = WC_W'(MEM_LAT - 2);
                    end
                end else if (is_ret) begin
                    F_stall_o  = 1'b1;
                    D_bubble_o = 1'b1;
                    ret_inc    = 1'b1;
                    if (RET_STALL > 1) begin
                        state_nxt = RET_WAIT;
                        wcnt_nxt  = WC_W'(RET_STALL - 2);
                    end
                end
            end
            LU_WAIT: begin
                F_stall_o  = 1'b1;
                D_stall_o  = 1'b1;
                E_bubble_o = 1'b1;
                state_nxt  = wcnt == '0 ? RUN : LU_WAIT;
                wcnt_nxt   = wcnt == '0 ? wcnt : wcnt - 1'b1;
            end
            RET_WAIT: begin
                F_stall_o  = 1'b1;
                D_bubble_o = 1'b1;
                E_bubble_o = mis;
                state_nxt  = wcnt == '0 ? RUN : RET_WAIT;
                wcnt_nxt   = wcnt == '0 ? wcnt : wcnt - 1'b1;
            end
            default: begin
                F_stall_o  = 1'b1;
                D_stall_o  = 1'b1;
                E_bubble_o = 1'b1;
                M_bubble_o = 1'b1;
                W_stall_o  = 1'b1;
            end
        endcase
        if (w_exc && state != HALT)
            state_nxt = HALT;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= RUN;
            wcnt          <= '0;
            exc_stat_o    <= SAOK;
            lu_cnt_o      <= '0;
            mispred_cnt_o <= '0;
            ret_cnt_o     <= '0;
        end else begin
            state         <= state_nxt;
            wcnt          <= wcnt_nxt;
            exc_stat_o    <= (w_exc && state != HALT) ? W_stat_i : exc_stat_o;
            lu_cnt_o      <= lu_cnt_o + CNT_W'(lu_inc && !(&lu_cnt_o));
            mispred_cnt_o <= mispred_cnt_o + CNT_W'(mis_inc && !(&mispred_cnt_o));
            ret_cnt_o     <= ret_cnt_o + CNT_W'(ret_inc && !(&ret_cnt_o));
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of hazard control; dut0 uses MEM_LAT=3/RET_STALL=3, dut1 single-cycle penalties
module tb_pipe_hazard_ctrl;
    localparam logic [3:0] INOP = 4'h1, IMRMOVQ = 4'h5, IOPQ = 4'h6, IJXX = 4'h7, IRET = 4'h9, IPOPQ = 4'hB;
    localparam logic [2:0] SAOK = 3'd1, SADR = 3'd2, SHLT = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM;
    logic       e_Cnd;
    logic [2:0] m_stat, W_stat;

    logic       f_st0, d_st0, d_bu0, e_bu0, m_bu0, w_st0, cc0, halt0;
    logic       f_st1, d_st1, d_bu1, e_bu1, m_bu1, w_st1, cc1, halt1;
    logic [2:0] exc0, exc1;
    logic [3:0] lu_c0, mis_c0, ret_c0, lu_c1, mis_c1, ret_c1;
    logic [31:0] ctl0, ctl1;

    int n_cmp = 0;
    int n_err = 0;

    assign ctl0 = {25'd0, f_st0, d_st0, d_bu0, e_bu0, m_bu0, w_st0, cc0};
    assign ctl1 = {25'd0, f_st1, d_st1, d_bu1, e_bu1, m_bu1, w_st1, cc1};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(4), .MEM_LAT(3), .RET_STALL(3), .CNT_W(4)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
        .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd), .M_icode_i(M_icode),
        .m_stat_i(m_stat), .W_stat_i(W_stat), .F_stall_o(f_st0), .D_stall_o(d_st0),
        .D_bubble_o(d_bu0), .E_bubble_o(e_bu0), .M_bubble_o(m_bu0), .W_stall_o(w_st0),
        .set_cc_o(cc0), .halted_o(halt0), .exc_stat_o(exc0), .lu_cnt_o(lu_c0),
        .mispred_cnt_o(mis_c0), .ret_cnt_o(ret_c0)
    );

    pipe_hazard_ctrl #(.REG_W(4), .MEM_LAT(1), .RET_STALL(1), .CNT_W(4)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
        .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd), .M_icode_i(M_icode),
        .m_stat_i(m_stat), .W_stat_i(W_stat), .F_stall_o(f_st1), .D_stall_o(d_st1),
        .D_bubble_o(d_bu1), .E_bubble_o(e_bu1), .M_bubble_o(m_bu1), .W_stall_o(w_st1),
        .set_cc_o(cc1), .halted_o(halt1), .exc_stat_o(exc1), .lu_cnt_o(lu_c1),
        .mispred_cnt_o(mis_c1), .ret_cnt_o(ret_c1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        D_icode = INOP; E_icode = INOP; M_icode = INOP;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
        e_Cnd = 1'b0; m_stat = SAOK; W_stat = SAOK;
    endtask

    task automatic lu_set();
        E_icode = IMRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) tick();
        rst_n = 1'b1;
        tick(); #1;
        check("rst_ctl", ctl0, 32'b0000000);
        check("rst_halt", {31'd0, halt0}, 32'd0);
        check("rst_exc", {29'd0, exc0}, {29'd0, SAOK});
        check("rst_cnt", {20'd0, lu_c0, mis_c0, ret_c0}, 32'd0);

        tick(); lu_set(); #1;
        check("lu_c0", ctl0, 32'b1101000);
        check("lu1_c0", ctl1, 32'b1101000);
        tick(); idle(); #1;
        check("lu_c1", ctl0, 32'b1101000);
        check("lu1_c1", ctl1, 32'b0000000);
        check("lu_cnt", {28'd0, lu_c0}, 32'd1);
        tick(); #1;
        check("lu_c2", ctl0, 32'b1101000);
        tick(); #1;
        check("lu_c3", ctl0, 32'b0000000);
        check("lu1_cnt", {28'd0, lu_c1}, 32'd1);

        tick(); E_icode = IPOPQ; E_dstM = 4'hF; d_srcB = 4'hF; #1;
        check("rnone_ctl", ctl0, 32'b0000000);
        tick(); idle(); #1;
        check("rnone_cnt", {28'd0, lu_c0}, 32'd1);

        tick(); E_icode = IPOPQ; E_dstM = 4'd5; d_srcB = 4'd5; #1;
        check("popq_c0", ctl0, 32'b1101000);
        tick(); idle();
        tick(); tick(); #1;
        check("popq_c3", ctl0, 32'b0000000);
        check("popq_cnt", {28'd0, lu_c0}, 32'd2);

        tick(); E_icode = IOPQ; #1;
        check("setcc", ctl0, 32'b0000001);
        m_stat = SADR; #1;
        check("setcc_mexc", ctl0, 32'b0000100);
        idle();

        tick(); D_icode = IRET; #1;
        check("ret_c0", ctl0, 32'b1010000);
        check("ret1_c0", ctl1, 32'b1010000);
        tick(); idle(); #1;
        check("ret_c1", ctl0, 32'b1010000);
        check("ret1_c1", ctl1, 32'b0000000);
        check("ret_cnt", {28'd0, ret_c0}, 32'd1);
        tick(); #1;
        check("ret_c2", ctl0, 32'b1010000);
        tick(); #1;
        check("ret_c3", ctl0, 32'b0000000);

        tick(); E_icode = IJXX; e_Cnd = 1'b0; D_icode = IRET; #1;
        check("mis_c0", ctl0, 32'b0011000);
        tick(); idle(); #1;
        check("mis_c1", ctl0, 32'b0000000);
        check("mis_cnt", {28'd0, mis_c0}, 32'd1);
        check("mis_ret_cnt", {28'd0, ret_c0}, 32'd1);

        tick(); E_icode = IJXX; e_Cnd = 1'b1; #1;
        check("taken_ctl", ctl0, 32'b0000000);
        tick(); idle(); #1;
        check("taken_cnt", {28'd0, mis_c0}, 32'd1);

        tick(); D_icode = IRET; #1;
        tick(); idle(); E_icode = IJXX; e_Cnd = 1'b0; #1;
        check("retw_mis", ctl0, 32'b1011000);
        tick(); idle();
        tick(); #1;
        check("retw_end", ctl0, 32'b0000000);
        check("retw_cnt", {28'd0, ret_c0}, 32'd2);

        tick(); lu_set(); E_dstM = 4'd2; d_srcA = 4'd2; D_icode = IRET; #1;
        check("luret_c0", ctl0, 32'b1101000);
        tick(); E_icode = INOP; E_dstM = 4'hF; d_srcA = 4'hF; #1;
        check("luret_c1", ctl0, 32'b1101000);
        tick(); #1;
        check("luret_c2", ctl0, 32'b1101000);
        tick(); #1;
        check("luret_c3", ctl0, 32'b1010000);
        tick(); idle(); #1;
        check("luret_c4", ctl0, 32'b1010000);
        check("luret_rcnt", {28'd0, ret_c0}, 32'd3);
        tick(); tick(); #1;
        check("luret_c6", ctl0, 32'b0000000);
        check("luret_lcnt", {28'd0, lu_c0}, 32'd3);

        for (int i = 0; i < 17; i++) begin
            tick(); lu_set();
            tick(); idle();
            tick(); tick();
            if (i == 10) check("sat_14", {28'd0, lu_c0}, 32'd14);
            if (i == 11) check("sat_15", {28'd0, lu_c0}, 32'd15);
        end
        check("sat_end", {28'd0, lu_c0}, 32'd15);
        check("sat1_end", {28'd0, lu_c1}, 32'd15);

        tick(); lu_set(); #1;
        tick(); idle(); #1;
        check("rstw_pre", ctl0, 32'b1101000);
        rst_n = 1'b0; #1;
        check("rstw_ctl", ctl0, 32'b0000000);
        check("rstw_cnt", {28'd0, lu_c0}, 32'd0);
        tick(); rst_n = 1'b1;

        tick(); W_stat = SHLT; E_icode = IOPQ; #1;
        check("halt_c0", ctl0, 32'b0000110);
        check("halt_c0_flag", {31'd0, halt0}, 32'd0);
        tick(); idle(); #1;
        check("halt_c1_flag", {31'd0, halt0}, 32'd1);
        check("halt_c1_exc", {29'd0, exc0}, {29'd0, SHLT});
        check("halt_c1_ctl", ctl0, 32'b1101110);
        check("halt1_flag", {31'd0, halt1}, 32'd1);
        lu_set(); #1;
        tick(); idle(); #1;
        check("halt_hold_ctl", ctl0, 32'b1101110);
        check("halt_frozen", {28'd0, lu_c0}, 32'd0);
        check("halt_hold_exc", {29'd0, exc0}, {29'd0, SHLT});
        rst_n = 1'b0; #1;
        check("halt_rst_flag", {31'd0, halt0}, 32'd0);
        check("halt_rst_exc", {29'd0, exc0}, {29'd0, SAOK});
        check("halt_rst_ctl", ctl0, 32'b0000000);
        tick(); rst_n = 1'b1;

        tick(); D_icode = IRET; #1;
        tick(); idle(); W_stat = SADR; #1;
        check("pre_halt_ctl", ctl0, 32'b1010110);
        tick(); idle(); #1;
        check("pre_halt_flag", {31'd0, halt0}, 32'd1);
        check("pre_halt_exc", {29'd0, exc0}, {29'd0, SADR});
        check("pre_halt_ctl2", ctl0, 32'b1101110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
